// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: configuration register file and frequency-sweep scheduler
// for the DDS core. Steps the tuning word from start to end by a fixed
// increment, holding each value for (dwell+1) divided-clock ticks.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   cfg_wr         register write strobe (cfg_addr / cfg_data)
//   cfg_addr[2:0]  0/1 start lo/hi, 2/3 end lo/hi, 4 step, 5 dwell,
//                  6 mode {loop, wsel[2:0]}, 7 unused
//   cfg_data[7:0]  register write data
//   start, stop    single-cycle sweep control pulses (stop wins)
//   tick           sweep advance enable from the clock divider
//   tuning         tuning word to the phase accumulator
//   sel            waveform select to the output mux
//   busy           high whenever the scheduler is not idle
//   done           one-cycle pulse when tuning reaches the end value
module dds_sweep_ctrl #(
    parameter int TUNE    = 16,
    parameter int DWELL_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_wr,
    input  logic [2:0]      cfg_addr,
    input  logic [7:0]      cfg_data,
    input  logic            start,
    input  logic            stop,
    input  logic            tick,
    output logic [TUNE-1:0] tuning,
    output logic [2:0]      sel,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;

    // Live configuration registers
    logic [TUNE-1:0]    start_q, end_q;
    logic [7:0]         step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [2:0]         sel_q;
    logic               loop_q;

    // Shadow copies taken when a sweep is accepted
    logic [TUNE-1:0]    s_start_q, s_end_q;
    logic [7:0]         s_step_q;
    logic [DWELL_W-1:0] s_dwell_q;
    logic               s_loop_q, dir_up_q;

    state_t             state_q;
    logic [TUNE-1:0]    tuning_q;
    logic               busy_q, done_q;
    // One extra bit: the end value holds one extra tick before a loop restart
    logic [DWELL_W:0]   dwell_cnt_q;
    logic               at_end_q;

    // Next step in 17-bit arithmetic so carry/borrow is visible
    logic [TUNE:0]      nxt17;
    logic [TUNE-1:0]    tune_d;
    logic               clamp;

    always_comb begin
        nxt17 = '0;
        clamp = 1'b0;
        if (dir_up_q) begin
            nxt17 = {1'b0, tuning_q} + {{(TUNE+1-8){1'b0}}, s_step_q};
            clamp = (nxt17 >= {1'b0, s_end_q});  // also catches carry out
        end else begin
            nxt17 = {1'b0, tuning_q} - {{(TUNE+1-8){1'b0}}, s_step_q};
            clamp = nxt17[TUNE] || (nxt17[TUNE-1:0] <= s_end_q);
        end
        tune_d = nxt17[TUNE-1:0];
    end

    // Register file; sel is the wsel field itself, so it tracks the write
    // one cycle later regardless of sweep state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            end_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            sel_q   <= '0;
            loop_q  <= 1'b0;
        end else if (cfg_wr) begin
            case (cfg_addr)
                3'd0: start_q[7:0]  <= cfg_data;
                3'd1: start_q[15:8] <= cfg_data;
                3'd2: end_q[7:0]    <= cfg_data;
                3'd3: end_q[15:8]   <= cfg_data;
                3'd4: step_q        <= cfg_data;
                3'd5: dwell_q       <= cfg_data;
                3'd6: begin
                    sel_q  <= cfg_data[2:0];
                    loop_q <= cfg_data[3];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tuning_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dwell_cnt_q <= '0;
            at_end_q    <= 1'b0;
            s_start_q   <= '0;
            s_end_q     <= '0;
            s_step_q    <= '0;
            s_dwell_q   <= '0;
            s_loop_q    <= 1'b0;
            dir_up_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                tuning_q    <= start_q;
                dwell_cnt_q <= '0;
                at_end_q    <= 1'b0;
            end else if (start) begin
                // Uses the pre-write register values if a write coincides
                s_start_q   <= start_q;
                s_end_q     <= end_q;
                s_step_q    <= step_q;
                s_dwell_q   <= dwell_q;
                s_loop_q    <= loop_q;
                dir_up_q    <= (end_q >= start_q);
                tuning_q    <= start_q;
                dwell_cnt_q <= {1'b0, dwell_q};
                at_end_q    <= 1'b0;
                busy_q      <= 1'b1;
                if (start_q == end_q) begin
                    state_q <= HOLD;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= SWEEP;
                end
            end else begin
                case (state_q)
                    IDLE: tuning_q <= start_q;
                    SWEEP: if (tick) begin
                        if (dwell_cnt_q != '0) begin
                            dwell_cnt_q <= dwell_cnt_q - 1'b1;
                        end else if (at_end_q) begin
                            tuning_q    <= s_start_q;
                            dwell_cnt_q <= {1'b0, s_dwell_q};
                            at_end_q    <= 1'b0;
                        end else if (clamp) begin
                            tuning_q <= s_end_q;
                            done_q   <= 1'b1;
                            if (s_loop_q) begin
                                at_end_q    <= 1'b1;
                                dwell_cnt_q <= {1'b0, s_dwell_q} + 1'b1;
                            end else begin
                                state_q <= HOLD;
                            end
                        end else begin
                            tuning_q    <= tune_d;
                            dwell_cnt_q <= {1'b0, s_dwell_q};
                        end
                    end
                    default: ;  // HOLD: tuning already parked at s_end
                endcase
            end
        end
    end

    assign tuning = tuning_q;
    assign sel    = sel_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        start = 1'b0, stop = 1'b0, tick = 1'b0;
    logic [15:0] tuning;
    logic [2:0]  sel;
    logic        busy, done;

    int n_chk = 0, n_pass = 0;

    dds_sweep_ctrl #(.TUNE(16), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .stop(stop), .tick(tick),
        .tuning(tuning), .sel(sel), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic cfg(input logic [15:0] s, input logic [15:0] e,
                       input logic [7:0] st, input logic [7:0] dw, input logic [7:0] md);
        wr(3'd0, s[7:0]);  wr(3'd1, s[15:8]);
        wr(3'd2, e[7:0]);  wr(3'd3, e[15:8]);
        wr(3'd4, st);      wr(3'd5, dw);
        wr(3'd6, md);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    initial begin
        int ndone, nchg, t0, t1, t2;
        logic [15:0] prev;
        logic [15:0] lexp [8];
        logic        ldone [8];

        // Reset state
        cyc(2);
        chk("rst_tuning", tuning, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        cyc(1);

        // Basic up sweep, dwell=2
        cfg(16'h0100, 16'h0104, 8'd1, 8'd2, 8'h02);
        chk("sel_after_wr", sel, 2);
        cyc(1);
        chk("idle_follow", tuning, 16'h0100);
        pulse_start();
        chk("sw_first", tuning, 16'h0100);
        chk("sw_busy", busy, 1);
        ndone = 0;
        tick = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (tuning !== 16'(16'h0100 + i / 3))
                chk("sw_seq", tuning, 16'h0100 + i / 3);
            if (done) ndone++;
            if (i == 12) chk("sw_done_at_end", done, 1);
        end
        cyc(3);
        if (done) ndone++;
        tick = 1'b0;
        chk("sw_done_once", ndone, 1);
        chk("sw_hold_val", tuning, 16'h0104);
        chk("sw_hold_busy", busy, 1);
        pulse_stop();
        chk("stop_busy", busy, 0);
        chk("stop_tuning", tuning, 16'h0100);

        // Clamp up without wrap
        cfg(16'hFFF0, 16'hFFFF, 8'h20, 8'd0, 8'h00);
        pulse_start();
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        chk("clamp_val", tuning, 16'hFFFF);
        chk("clamp_done", done, 1);
        cyc(1);
        chk("clamp_done_off", done, 0);
        chk("clamp_busy", busy, 1);
        pulse_stop();

        // Down sweep with loop
        cfg(16'h0050, 16'h0040, 8'd8, 8'd0, 8'h08);
        pulse_start();
        chk("dn_first", tuning, 16'h0050);
        lexp  = '{16'h48, 16'h40, 16'h40, 16'h50, 16'h48, 16'h40, 16'h40, 16'h50};
        ldone = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("dn_tune%0d", i), tuning, lexp[i]);
            chk($sformatf("dn_done%0d", i), done, ldone[i]);
        end
        tick = 1'b0;
        chk("dn_busy", busy, 1);
        pulse_stop();

        // Mid-sweep write of end does not affect the sweep
        cfg(16'h0010, 16'h0014, 8'd1, 8'd0, 8'h00);
        pulse_start();
        tick = 1'b1; cyc(2); tick = 1'b0;
        chk("mid_pre", tuning, 16'h0012);
        wr(3'd2, 8'h00); wr(3'd3, 8'h02);
        tick = 1'b1; cyc(2);
        chk("mid_end", tuning, 16'h0014);
        chk("mid_done", done, 1);
        cyc(3); tick = 1'b0;
        chk("mid_hold", tuning, 16'h0014);
        chk("mid_busy", busy, 1);
        start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_tuning", tuning, 16'h0010);
        chk("ss_done", done, 0);

        // Sparse ticks: dwell=1, tick every 14 clk -> change every 28 clk
        wr(3'd5, 8'd1); wr(3'd6, 8'h05);
        pulse_start();
        prev = tuning; nchg = 0; t0 = 0; t1 = 0; t2 = 0;
        for (int c = 0; c < 84; c++) begin
            tick = (c % 14 == 13);
            @(negedge clk);
            if (tuning !== prev) begin
                if (nchg == 0) t0 = c; else if (nchg == 1) t1 = c; else t2 = c;
                nchg++;
                prev = tuning;
            end
        end
        tick = 1'b0;
        chk("sp_nchg", nchg, 3);
        chk("sp_gap1", t1 - t0, 28);
        chk("sp_gap2", t2 - t1, 28);
        chk("sp_val", tuning, 16'h0013);
        chk("sp_sel", sel, 5);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_tuning", tuning, 0);
        chk("arst_sel", sel, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        cyc(1);

        // start == end
        cfg(16'h1234, 16'h1234, 8'd1, 8'd0, 8'h00);
        pulse_start();
        chk("eq_done", done, 1);
        chk("eq_tuning", tuning, 16'h1234);
        cyc(1);
        chk("eq_done_off", done, 0);
        tick = 1'b1; cyc(4); tick = 1'b0;
        chk("eq_hold", tuning, 16'h1234);
        chk("eq_busy", busy, 1);
        pulse_stop();

        // step == 0: never advances, never done
        wr(3'd2, 8'h00); wr(3'd3, 8'h20); wr(3'd4, 8'd0);
        pulse_start();
        ndone = 0; nchg = 0;
        tick = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (tuning !== 16'h1234) nchg++;
        end
        tick = 1'b0;
        chk("z_done", ndone, 0);
        chk("z_chg", nchg, 0);
        chk("z_busy", busy, 1);
        pulse_stop();
        chk("z_stop", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
